// File: rtl/key_sched_ctrl.sv
// AES-128 key schedule sequencer around key_expansion: round counter, prev_key feedback,
// valid/ready round-key stream. Optional round-key store enabled by ROUND_KEY_STORE_EN.
module key_sched_ctrl #(
  parameter int NUM_ROUNDS = 11,
  parameter int KW         = 128
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [KW-1:0] key,
  input  logic [KW-1:0] round_key_in,
  output logic [3:0]    round,
  output logic [KW-1:0] prev_key,
  output logic [KW-1:0] key_out,
  output logic          rk_valid,
  input  logic          rk_ready,
  output logic [KW-1:0] rk_data,
  output logic [3:0]    rk_round,
  output logic          busy,
  output logic          done,
  input  logic [3:0]    rd_idx,
  output logic [KW-1:0] rd_key
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_CAPTURE,
    S_DONE
  } state_t;

  localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

  state_t        state;
  logic [KW-1:0] rk_hold;
  logic          hs;

  assign hs = rk_valid & rk_ready;

  // key_expansion's result is only valid during LOAD/CAPTURE, so the stream passes it
  // through live there and otherwise shows the last accepted key.
  assign rk_data = (state == S_LOAD || state == S_CAPTURE) ? round_key_in : rk_hold;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      round    <= '0;
      prev_key <= '0;
      key_out  <= '0;
      rk_hold  <= '0;
      rk_round <= '0;
      rk_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            key_out  <= key;
            prev_key <= key;
            round    <= 4'd1;
            rk_round <= 4'd1;
            rk_valid <= 1'b1;
            busy     <= 1'b1;
            state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (hs) begin
            rk_hold  <= round_key_in;
            round    <= 4'd2;
            rk_valid <= 1'b0;
            state    <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          rk_valid <= 1'b1;
          rk_round <= round;
          state    <= S_CAPTURE;
        end
        S_CAPTURE: begin
          if (hs) begin
            rk_hold  <= round_key_in;
            prev_key <= round_key_in;
            rk_valid <= 1'b0;
            if (round == LAST) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              round <= round + 4'd1;
              state <= S_SETTLE;
            end
          end
        end
        S_DONE: begin
          round <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef ROUND_KEY_STORE_EN
  logic [KW-1:0] store [1:NUM_ROUNDS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 1; i <= NUM_ROUNDS; i++) store[i] <= '0;
    end else if (hs) begin
      store[rk_round] <= round_key_in;
    end
  end

  always_comb begin
    rd_key = '0;
    if (rd_idx >= 4'd1 && rd_idx <= LAST) rd_key = store[rd_idx];
  end
`else
  logic unused_rd;
  assign unused_rd = ^rd_idx;
  assign rd_key    = '0;
`endif

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Bench for key_sched_ctrl: behavioural key_expansion (clocked S-box) plus a scoreboard of
// expected round keys pushed at each accepted start and popped on every handshake.
module tb_key_sched_ctrl;

  localparam logic [127:0] K1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] R2   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] R11  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K2   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] R11B = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key;
  logic [127:0] round_key_in;
  logic [3:0]   round;
  logic [127:0] prev_key;
  logic [127:0] key_out;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_data;
  logic [3:0]   rk_round;
  logic         busy;
  logic         done;
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;

  key_sched_ctrl #(.NUM_ROUNDS(11), .KW(128)) dut (
    .clk(clk), .reset(rst), .start(start), .key(key), .round_key_in(round_key_in),
    .round(round), .prev_key(prev_key), .key_out(key_out), .rk_valid(rk_valid),
    .rk_ready(rk_ready), .rk_data(rk_data), .rk_round(rk_round), .busy(busy),
    .done(done), .rd_idx(rd_idx), .rd_key(rd_key)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] v);
    logic [7:0] inv, s;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, v);
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
        ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    return s;
  endfunction

  function automatic logic [31:0] subrot(input logic [31:0] w);
    logic [31:0] r;
    r = {w[23:0], w[31:24]};
    return {sbox(r[31:24]), sbox(r[23:16]), sbox(r[15:8]), sbox(r[7:0])};
  endfunction

  function automatic logic [127:0] expand(input logic [127:0] p, input logic [31:0] sw,
                                          input logic [3:0] r);
    logic [7:0]  rc;
    logic [31:0] n0, n1, n2, n3;
    rc = 8'h01;
    for (int i = 2; i < int'(r); i++) rc = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
    n0 = p[127:96] ^ sw ^ {rc, 24'h0};
    n1 = p[95:64] ^ n0;
    n2 = p[63:32] ^ n1;
    n3 = p[31:0]  ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // key_expansion stand-in: round 1 is combinational, later rounds use a registered S-box
  logic [31:0] sub_reg;
  always @(posedge clk) sub_reg <= subrot(prev_key[31:0]);
  always_comb begin
    round_key_in = key_out;
    if (round != 4'd1) round_key_in = expand(prev_key, sub_reg, round);
  end

  typedef struct {
    logic [3:0]   r;
    logic [127:0] k;
  } exp_t;

  exp_t         exp_q[$];
  int           cyc = 0;
  int           start_cyc = 0;
  int           hs_count = 0;
  int           r11_cyc = 0;
  logic [127:0] got_keys [0:15];
  logic         prev_stall = 1'b0;
  logic [127:0] prev_data;
  logic [3:0]   prev_round;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", rk_valid, 1);
        check("hold_data", rk_data, prev_data);
        check("hold_round", rk_round, prev_round);
      end
      if (rk_valid && rk_ready) begin
        hs_count++;
        got_keys[rk_round] = rk_data;
        if (rk_round == 4'd11) r11_cyc = cyc - start_cyc;
        if (exp_q.size() == 0) begin
          check("hs_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("sb_round", rk_round, e.r);
          check("sb_key", rk_data, e.k);
        end
      end
      prev_stall = rk_valid && !rk_ready;
      prev_data  = rk_data;
      prev_round = rk_round;
    end
  end

  task automatic push_sched(input logic [127:0] k);
    exp_t e;
    logic [127:0] p;
    p = k;
    e.r = 4'd1; e.k = k;
    exp_q.push_back(e);
    for (int r = 2; r <= 11; r++) begin
      p = expand(p, subrot(p[31:0]), 4'(r));
      e.r = 4'(r); e.k = p;
      exp_q.push_back(e);
    end
  endtask

  // caller sits just after a rising edge; the following edge is edge 0
  task automatic start_sched(input logic [127:0] k);
    key = k;
    start = 1'b1;
    hs_count = 0;
    push_sched(k);
    @(posedge clk); #1;
    start = 1'b0;
    start_cyc = cyc - 1;
  endtask

  task automatic wait_done(output int lat);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 200);
    if (!done) check("done_timeout", 0, 1);
    lat = cyc - start_cyc;
  endtask

  task automatic wait_round(input logic [3:0] r);
    int n;
    n = 0;
    while (!(rk_valid && rk_round == r) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) check("wait_round_timeout", 0, 1);
  endtask

  initial begin
    int lat;
    rst = 1'b1; start = 1'b0; key = '0; rk_ready = 1'b1; rd_idx = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_round", round, 0);
    check("rst_valid", rk_valid, 0);
    check("rst_data", rk_data, 0);
    check("rst_rk_round", rk_round, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_prev_key", prev_key, 0);
    check("rst_key_out", key_out, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // FIPS-197 schedule with the consumer always ready
    start_sched(K1);
    check("t1_round1", round, 1);
    check("t1_busy", busy, 1);
    check("t1_key_out", key_out, K1);
    wait_done(lat);
    check("t1_done_cycle", lat, 22);
    check("t1_r11_cycle", r11_cyc, 21);
    check("t1_hs_count", hs_count, 11);
    check("t1_r2_key", got_keys[2], R2);
    check("t1_r11_key", got_keys[11], R11);
    check("t1_sb_drain", exp_q.size(), 0);
    @(posedge clk); #1;
    check("t1_idle_busy", busy, 0);
    check("t1_idle_round", round, 0);
    check("t1_idle_data", rk_data, R11);
    check("t1_idle_prev", prev_key, R11);

`ifdef ROUND_KEY_STORE_EN
    rd_idx = 4'd1;  #1; check("store_1", rd_key, K1);
    rd_idx = 4'd11; #1; check("store_11", rd_key, R11);
    rd_idx = 4'd0;  #1; check("store_0", rd_key, 0);
    rd_idx = 4'd12; #1; check("store_12", rd_key, 0);
`else
    rd_idx = 4'd1;  #1; check("nostore_1", rd_key, 0);
    rd_idx = 4'd11; #1; check("nostore_11", rd_key, 0);
`endif
    rd_idx = '0;
    @(posedge clk); #1;

    // three-cycle stall at round 5
    start_sched(K1);
    wait_round(4'd5);
    rk_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("t2_stall_round", rk_round, 5);
    end
    rk_ready = 1'b1;
    wait_done(lat);
    check("t2_done_cycle", lat, 25);
    check("t2_hs_count", hs_count, 11);
    check("t2_r11_key", got_keys[11], R11);
    check("t2_sb_drain", exp_q.size(), 0);
    @(posedge clk); #1;

    // asynchronous reset at round 6, then immediate restart with a second key
    start_sched(K1);
    wait_round(4'd6);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("t3_rst_round", round, 0);
    check("t3_rst_valid", rk_valid, 0);
    check("t3_rst_data", rk_data, 0);
    check("t3_rst_rk_round", rk_round, 0);
    check("t3_rst_busy", busy, 0);
    check("t3_rst_prev", prev_key, 0);
    check("t3_rst_key_out", key_out, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    start_sched(K2);
    check("t3_restart_round", round, 1);
    wait_done(lat);
    check("t3_done_cycle", lat, 22);
    check("t3_r11_key", got_keys[11], R11B);
    check("t3_sb_drain", exp_q.size(), 0);
    @(posedge clk); #1;

    // start pulse while busy is ignored
    start_sched(K1);
    wait_round(4'd4);
    key = K2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat);
    check("t4_done_cycle", lat, 22);
    check("t4_hs_count", hs_count, 11);
    check("t4_key_out", key_out, K1);
    check("t4_r11_key", got_keys[11], R11);
    check("t4_sb_drain", exp_q.size(), 0);

    // start held from the done cycle into the next: only the second sample is taken
    key = K2;
    start = 1'b1;
    @(posedge clk); #1;
    check("t5_coincident_busy", busy, 0);
    check("t5_coincident_round", round, 0);
    hs_count = 0;
    push_sched(K2);
    @(posedge clk); #1;
    start = 1'b0;
    start_cyc = cyc - 1;
    check("t5_b2b_round", round, 1);
    check("t5_b2b_busy", busy, 1);
    check("t5_b2b_key_out", key_out, K2);
    wait_done(lat);
    check("t5_done_cycle", lat, 22);
    check("t5_hs_count", hs_count, 11);
    check("t5_r11_key", got_keys[11], R11B);
    check("t5_sb_drain", exp_q.size(), 0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
